sync_ram: RTL
=============

SYNC_RAM -- requirements
Module: sync_ram

Interface
REQ-001 Parameter DATA_W, default 32, word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, default 256, number of words; SHALL be at least 2.
REQ-003 Parameter ADDR_W, default 32, request word-address width.
REQ-004 Port clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 Port rst  in  1  reset, synchronous, active-high.
REQ-006 Port clr  in  1  soft clear request, sampled on the clk edge.
REQ-007 Port req_valid  in  1  request present.
REQ-008 Port req_ready  out  1  block accepts a request this cycle.
REQ-009 Port req_we  in  1  1 = write, 0 = read.
REQ-010 Port req_addr  in  ADDR_W  word address.
REQ-011 Port req_wdata  in  DATA_W  write data.
REQ-012 Port req_be  in  DATA_W/8  byte-lane write enables; bit i covers bits [8i+7:8i].
REQ-013 Port rsp_valid  out  1  read response valid, one-cycle pulse.
REQ-014 Port rsp_rdata  out  DATA_W  read data.
REQ-015 Port rsp_err  out  1  out-of-range flag, qualified by rsp_valid.
REQ-016 Port init_busy  out  1  clear sequence in progress.

Function
REQ-017 The FSM SHALL have exactly two states, CLEAR and IDLE.
REQ-018 In CLEAR, the block SHALL write zero to word clr_cnt each cycle, increment clr_cnt, and go to IDLE after word DEPTH-1 is written, so CLEAR lasts exactly DEPTH cycles.
REQ-019 init_busy SHALL be 1 in CLEAR and 0 in IDLE; req_ready SHALL equal the inverse of init_busy.
REQ-020 A request SHALL be accepted only on a cycle with req_valid=1 and req_ready=1; req_valid during CLEAR SHALL be ignored and no response generated.
REQ-021 An accepted read SHALL assert rsp_valid for exactly the next cycle, with rsp_rdata set to the word stored at req_addr at acceptance (latency 1).
REQ-022 An accepted write SHALL update the addressed word at that edge and SHALL NOT generate a response.
REQ-023 A read accepted the cycle after a write to the same address SHALL return the new data.
REQ-024 req_addr >= DEPTH SHALL be out of range; writes SHALL be dropped and reads SHALL return rsp_rdata=0 with rsp_err=1.
REQ-025 rsp_err SHALL be 0 for in-range reads; when rsp_valid=0, rsp_rdata and rsp_err SHALL be 0.
REQ-026 Back-to-back reads SHALL be accepted every cycle in IDLE, giving one rsp_valid pulse per read.
REQ-027 clr=1 in IDLE SHALL move the FSM to CLEAR with clr_cnt=0 on the next edge; any request in that same cycle SHALL still be accepted and completed.
REQ-028 clr=1 during CLEAR SHALL restart clr_cnt at 0.

Reset
REQ-029 rst=1 SHALL force state CLEAR, clr_cnt=0, rsp_valid=0, rsp_rdata=0 and rsp_err=0 on the next edge; init_busy SHALL be 1 and req_ready 0.
REQ-030 rst SHALL take priority over clr and requests; rst asserted mid-CLEAR SHALL restart the clear from word 0.
REQ-031 A read accepted in the cycle before rst is asserted SHALL NOT produce rsp_valid.

Configuration
REQ-032 Macro SYNC_RAM_BYTE_WRITE_EN controls byte-lane writes.
REQ-033 With the macro defined, a write SHALL update only the byte lanes whose req_be bit is 1; req_be=0 SHALL leave the word unchanged.
REQ-034 With the macro undefined, req_be SHALL be ignored and every write SHALL update the full word.

Verification
REQ-035 Release rst after 2 cycles -> init_busy=1 for exactly 256 cycles, then req_ready=1; reading addresses 0, 128 and 255 -> rsp_rdata=0x00000000.
REQ-036 Write 0xDEADBEEF to 5, read 5 next cycle -> rsp_valid one cycle later, rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-037 Write 0x11223344 to 7, then write 0xAABBCCDD to 7 with req_be=4'b0101, read 7 -> rsp_rdata=0x11BB33DD with macro defined, 0xAABBCCDD without it.
REQ-038 Read address 256 -> rsp_valid=1, rsp_rdata=0, rsp_err=1; write 0x1 to 256 -> no word changes and no response.
REQ-039 Assert clr at 10 cycles into CLEAR, and separately assert rst at 100 cycles into CLEAR -> init_busy stays 1 for a further 256 cycles after each, and all words read 0 afterwards.
REQ-040 Four back-to-back reads of 1..4 preloaded with 0xA1..0xA4 -> four consecutive rsp_valid pulses carrying 0xA1..0xA4 in order.

Source files
------------

// File: rtl/sync_ram.sv
// Single-port word RAM with a valid/ready request side, 1-cycle read latency and hardware self-clear.
// Define SYNC_RAM_BYTE_WRITE_EN to honour req_be byte-lane write enables.
module sync_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                init_busy
);

    localparam int AW   = $clog2(DEPTH);
    localparam int BE_W = DATA_W / 8;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic {CLEAR, IDLE} state_e;

    state_e              state_q, state_d;
    logic [AW-1:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;

    logic                acc;
    logic                in_range;
    logic                rd;
    logic                wr;
    logic [AW-1:0]       idx;

    assign in_range = req_addr < ADDR_W'(DEPTH);
    assign idx      = req_addr[AW-1:0];
    assign acc      = req_valid && req_ready && !rst;
    assign rd       = acc && !req_we;
    assign wr       = acc && req_we && in_range;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            CLEAR: begin
                if (clr) begin
                    cnt_d = '0;
                end else if (cnt_q == LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            IDLE: begin
                if (clr) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        init_busy = (state_q == CLEAR);
        req_ready = !init_busy;
    end

    // Clear writes and request writes are exclusive: requests only land in IDLE.
    always_ff @(posedge clk) begin
        if (!rst && state_q == CLEAR) begin
            mem_q[cnt_q] <= '0;
        end else if (wr) begin
`ifdef SYNC_RAM_BYTE_WRITE_EN
            for (int i = 0; i < BE_W; i++) begin
                if (req_be[i]) begin
                    mem_q[idx][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
`else
            mem_q[idx] <= req_wdata;
`endif
        end
    end

`ifndef SYNC_RAM_BYTE_WRITE_EN
    logic unused_be;
    assign unused_be = ^req_be;
`endif

    always_comb begin
        rsp_valid_d = rd;
        rsp_err_d   = rd && !in_range;
        rsp_rdata_d = '0;
        if (rd && in_range) begin
            rsp_rdata_d = mem_q[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // A response pending when reset arrives is squashed immediately.
    assign rsp_valid = rsp_valid_q && !rst;
    assign rsp_rdata = rst ? '0 : rsp_rdata_q;
    assign rsp_err   = rsp_err_q && !rst;

endmodule
